// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared constants and helpers for the seven-segment scan controller
package seg_scan_ctrl_pkg;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic       ACTIVE_LOW = 1'b0;

  // Width of the per-slot tick counter; never narrower than one bit.
  function automatic int tick_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// rtl/seg_scan_timer.sv - slot tick counter and digit index for the scan controller
module seg_scan_timer
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int IW           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [IW-1:0] idx,
  output logic          slot_end,
  output logic          frame_end,
  output logic          in_blank
);

  localparam int TW = tick_width(REFRESH_DIV);

  logic [TW-1:0] tick;

  assign slot_end  = (tick == TW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));
  assign in_blank  = (tick < TW'(BLANK_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= '0;
      idx  <= '0;
    end else if (slot_end) begin
      tick <= '0;
      idx  <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      tick <= tick + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - double-buffered multiplexed scan of common-anode seven-segment digits
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [3:0]              dec_bcd,
  output logic                    dec_blank,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    upd_done,
  output logic                    bcd_err
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  logic [DW-1:0]         shadow, active;
  logic [NUM_DIGITS-1:0] dp_shadow, dp_active;
  logic                  pending;

  logic [IW-1:0]         idx;
  logic                  slot_end, frame_end, in_blank;

  logic [3:0]            cur_digit;
  logic                  upper_zero, suppress, load_bad;
  logic [NUM_DIGITS-1:0] anode_sel;

  seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .IW          (IW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx      (idx),
    .slot_end (slot_end),
    .frame_end(frame_end),
    .in_blank (in_blank)
  );

  always_comb begin
    cur_digit  = 4'(active >> {idx, 2'b00});
    upper_zero = 1'b1;
    load_bad   = 1'b0;
    anode_sel  = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) >= idx && active[4*k +: 4] != 4'd0) upper_zero = 1'b0;
      if (digits_in[4*k +: 4] > BCD_MAX) load_bad = 1'b1;
      if (IW'(k) == idx) anode_sel[k] = ACTIVE_LOW;
    end
    // Digit 0 always shows, so a value of zero still reads "0".
    suppress = lz_en && (idx != '0) && upper_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n      <= '1;
      dp_n      <= 1'b1;
      dec_bcd   <= 4'd0;
      dec_blank <= 1'b1;
      upd_done  <= 1'b0;
    end else begin
      upd_done <= frame_end && pending;
      dec_bcd  <= cur_digit;
      if (in_blank) begin
        an_n      <= '1;
        dp_n      <= 1'b1;
        dec_blank <= 1'b1;
      end else begin
        // Anode stays on for a blanked digit so its decimal point remains visible.
        an_n      <= anode_sel;
        dp_n      <= dp_active[idx] ? ACTIVE_LOW : ~ACTIVE_LOW;
        dec_blank <= (cur_digit > BCD_MAX) || suppress;
      end
    end
  end

  // The boundary copies the shadow as it stood before any same-cycle load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      dp_shadow <= '0;
      active    <= '0;
      dp_active <= '0;
      pending   <= 1'b0;
      bcd_err   <= 1'b0;
    end else begin
      if (frame_end && pending) begin
        active    <= shadow;
        dp_active <= dp_shadow;
      end
      if (load) begin
        shadow    <= digits_in;
        dp_shadow <= dp_in;
        pending   <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
      if (load && load_bad) bcd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [15:0]  digits_in = 16'h0;
  logic [3:0]   dp_in = 4'h0;
  logic         lz_en = 1'b1;
  logic [3:0]   dec_bcd;
  logic         dec_blank;
  logic [3:0]   an_n;
  logic         dp_n;
  logic         upd_done;
  logic         bcd_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic chk_on = 1'b0;

  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .digits_in(digits_in),
    .dp_in    (dp_in),
    .lz_en    (lz_en),
    .dec_bcd  (dec_bcd),
    .dec_blank(dec_blank),
    .an_n     (an_n),
    .dp_n     (dp_n),
    .upd_done (upd_done),
    .bcd_err  (bcd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t cyc=%0d: got %0h expected %0h", nm, $time, cyc, act, exp);
    end
  endtask

  // Model: cycle count since reset release gives slot position; buffers follow the load/boundary rules.
  int          m_cyc = 0;
  logic [15:0] m_shadow = 16'h0, m_active = 16'h0;
  logic [3:0]  m_dsh = 4'h0, m_dact = 4'h0;
  logic        m_pending = 1'b0, m_err = 1'b0;
  logic [3:0]  e_an = 4'hF, e_bcd = 4'h0;
  logic        e_blank = 1'b1, e_dp = 1'b1, e_upd = 1'b0, e_drive = 1'b0;

  int          t_c, i_c;
  logic        fe_c, sup_c, bad_in_c;
  logic [15:0] hi_c;
  logic [3:0]  dig_c;

  always_comb begin
    t_c      = m_cyc % R;
    i_c      = (m_cyc / R) % N;
    fe_c     = (t_c == R - 1) && (i_c == N - 1);
    hi_c     = m_active >> (4 * i_c);
    dig_c    = hi_c[3:0];
    sup_c    = lz_en && (i_c > 0) && (hi_c == 16'h0);
    bad_in_c = 1'b0;
    for (int k = 0; k < N; k++) if (digits_in[4*k +: 4] > 4'd9) bad_in_c = 1'b1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0; m_shadow <= 16'h0; m_active <= 16'h0; m_dsh <= 4'h0; m_dact <= 4'h0;
      m_pending <= 1'b0; m_err <= 1'b0;
      e_an <= 4'hF; e_bcd <= 4'h0; e_blank <= 1'b1; e_dp <= 1'b1; e_upd <= 1'b0; e_drive <= 1'b0;
    end else begin
      m_cyc   <= m_cyc + 1;
      e_drive <= (t_c >= B);
      if (t_c < B) begin
        e_an <= 4'hF; e_blank <= 1'b1; e_dp <= 1'b1;
      end else begin
        e_an    <= ~(4'b0001 << i_c);
        e_bcd   <= dig_c;
        e_blank <= (dig_c > 4'd9) || sup_c;
        e_dp    <= ~m_dact[i_c[1:0]];
      end
      e_upd <= fe_c && m_pending;
      if (fe_c && m_pending) begin
        m_active <= m_shadow;
        m_dact   <= m_dsh;
      end
      if (load) begin
        m_shadow <= digits_in; m_dsh <= dp_in; m_pending <= 1'b1;
      end else if (fe_c) begin
        m_pending <= 1'b0;
      end
      if (load && bad_in_c) m_err <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("an_n", 32'(an_n), 32'(e_an));
      check("dec_blank", 32'(dec_blank), 32'(e_blank));
      check("dp_n", 32'(dp_n), 32'(e_dp));
      check("upd_done", 32'(upd_done), 32'(e_upd));
      check("bcd_err", 32'(bcd_err), 32'(m_err));
      if (e_drive) check("dec_bcd", 32'(dec_bcd), 32'(e_bcd));
    end
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic go(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    load = 1'b1; digits_in = d; dp_in = dp;
    step();
    load = 1'b0;
  endtask

  initial begin
    #1 chk_on = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst an_n", 32'(an_n), 32'hF);
    check("rst dec_blank", 32'(dec_blank), 32'h1);
    check("rst dec_bcd", 32'(dec_bcd), 32'h0);
    check("rst upd_done", 32'(upd_done), 32'h0);
    rst_n = 1'b1; cyc = 0;

    // Idle scan of all zeros with leading-zero suppression.
    go(1);  check("idle blank an_n", 32'(an_n), 32'hF);
    go(3);  check("idle d0 an_n", 32'(an_n), 32'hE);
            check("idle d0 dec_blank", 32'(dec_blank), 32'h0);
    go(11); check("idle d1 an_n", 32'(an_n), 32'hD);
            check("idle d1 dec_blank", 32'(dec_blank), 32'h1);
    go(27); check("idle d3 an_n", 32'(an_n), 32'h7);

    // Mid-frame load appears only after the boundary.
    go(40); do_load(16'h1234, 4'b0100);
    go(63); check("no early upd", 32'(upd_done), 32'h0);
    go(64); check("upd 1234", 32'(upd_done), 32'h1);
    go(67); check("1234 d0 bcd", 32'(dec_bcd), 32'h4);
    go(83); check("1234 d2 bcd", 32'(dec_bcd), 32'h2);
            check("1234 d2 dp_n", 32'(dp_n), 32'h0);

    // Leading-zero suppression on and off.
    go(100); do_load(16'h0050, 4'b0000);
    go(139); check("0050 d1 bcd", 32'(dec_bcd), 32'h5);
    go(155); check("0050 d3 lz blank", 32'(dec_blank), 32'h1);
             check("0050 d3 an_n", 32'(an_n), 32'h7);
    go(160); lz_en = 1'b0;
    go(187); check("0050 d3 no-lz blank", 32'(dec_blank), 32'h0);

    // Invalid BCD digit.
    go(195); do_load(16'h12A4, 4'b0000);
    check("bcd_err set", 32'(bcd_err), 32'h1);
    go(235); check("12A4 d1 an_n", 32'(an_n), 32'hD);
             check("12A4 d1 blank", 32'(dec_blank), 32'h1);

    // Back-to-back loads inside one frame.
    go(260); do_load(16'h1111, 4'b0000);
    go(263); do_load(16'h2222, 4'b0000);
    go(291); check("2222 d0 bcd", 32'(dec_bcd), 32'h2);

    // Load on the boundary cycle, then reset mid-frame.
    go(300); do_load(16'h3456, 4'b0001);
    go(319); do_load(16'h7890, 4'b0000);
    check("boundary upd", 32'(upd_done), 32'h1);
    go(323); check("3456 d0 bcd", 32'(dec_bcd), 32'h6);
             check("3456 d0 dp_n", 32'(dp_n), 32'h0);
    go(330);
    #2 rst_n = 1'b0;
    #1;
    check("async an_n", 32'(an_n), 32'hF);
    check("async blank", 32'(dec_blank), 32'h1);
    check("async dp_n", 32'(dp_n), 32'h1);
    check("async bcd_err", 32'(bcd_err), 32'h0);
    step(); step(); step();
    rst_n = 1'b1; cyc = 0;
    go(3);  check("post-rst d0 bcd", 32'(dec_bcd), 32'h0);
    go(80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode seven-segment digits that share one BCD-to-seven-segment decoder. It double-buffers a packed BCD word and drives the shared decoder's BCD input and blank control, plus the per-digit anode and decimal-point lines. Each digit gets an equal refresh slot. Display updates are applied only at frame boundaries, so the display never tears. It sits between the value-producing logic and the decoder/pin layer.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 50000, clock cycles per digit slot (>= BLANK_CYCLES+2)
BLANK_CYCLES, 16, anti-ghost cycles at the start of each slot with all anodes off

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  single-cycle strobe: capture digits_in/dp_in into the shadow buffer
digits_in  in  4*NUM_DIGITS  packed BCD; digit k = [4k+3:4k], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal-point enable per digit
lz_en  in  1  leading-zero suppression enable (static)
dec_bcd  out  4  BCD code to the shared decoder
dec_blank  out  1  1 = decoder output forced off
an_n  out  NUM_DIGITS  active-low anode enables, at most one low
dp_n  out  1  active-low decimal point for the current digit
upd_done  out  1  one-cycle pulse: shadow data became active
bcd_err  out  1  sticky: a loaded digit was >9; cleared only by reset

Behaviour:
- Reset is async on rst_n low. Reset values: tick=0, idx=0, shadow=0, active=0, pending=0, an_n=all 1, dp_n=1, dec_bcd=0, dec_blank=1, upd_done=0, bcd_err=0. The first scan starts at idx 0 on the first clock after release.
- tick counts 0..REFRESH_DIV-1 and wraps. At tick=REFRESH_DIV-1, idx advances and wraps from NUM_DIGITS-1 to 0.
- All outputs are registered and reflect the tick/idx of the previous cycle (1-cycle latency).
- Blanking window: while tick<BLANK_CYCLES, an_n=all 1, dec_blank=1, dp_n=1.
- Drive window: otherwise, an_n[idx]=0, dec_bcd=active digit idx, dp_n=~dp_active[idx], and dec_blank is set by the rules below.
- dec_blank=1 in the drive window if any of these holds:
  - the digit is >9 (invalid codes are never passed to the decoder);
  - lz_en=1, idx>0, and digit idx and every higher digit are 0.
- Digit 0 is never zero-suppressed.
- The anode stays on when a digit is blanked, so dp_n still shows.
- Load: when load=1, shadow<=digits_in/dp_in and pending<=1. bcd_err<=1 if any nibble is >9.
- A repeated load before the frame boundary overwrites the shadow. Only the last load is shown.
- Frame boundary is tick=REFRESH_DIV-1 with idx=NUM_DIGITS-1. At a boundary with pending=1: active<=shadow, pending<=0, and upd_done=1 on the next cycle.
- Load on the same cycle as a boundary: the boundary transfers the pre-load shadow. The new load sets pending=1 and becomes active at the following boundary.
- With no pending data, the boundary has no effect and upd_done stays 0.
- Reset mid-frame discards shadow, active and pending immediately.

Decomposition:
- Shared package: constant BCD_MAX=9; anode/dp polarity constants ACTIVE_LOW=1'b0; function/localparam for the tick counter width, $clog2(REFRESH_DIV).
- One natural sub-module, seg_scan_timer: tick/idx counters. Outputs are idx, slot_end, frame_end and in_blank.
- Buffering, suppression and output registers stay in the top.

Test Plan:
(Run the bench with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.)
1. Reset then idle -> an_n=4'b1111 for the first 2 cycles of each slot. The active low anode then walks 1110,1101,1011,0111 in 6-cycle windows with dec_blank=1 (all zeros, lz_en=1, digits 3..1 suppressed; digit 0 shows 0, dec_blank=0). Period 32 cycles.
2. load digits_in=16'h1234, dp_in=4'b0100, mid-frame -> no change until the frame boundary, then upd_done pulses once. Next frame: dec_bcd=4,3,2,1 on idx 0..3, and dp_n=0 only in the idx 2 window.
3. lz_en=1, load 16'h0050 -> idx3 and idx2 blanked, idx1 shows 5, idx0 shows 0. With lz_en=0, all four are unblanked (0,0,5,0).
4. load 16'h12A4 -> bcd_err=1 and stays 1. The idx1 window has dec_blank=1 with an_n low. The other digits display normally.
5. load 16'h1111, then load 16'h2222 three cycles later, both before the boundary -> a single upd_done. Frame shows 2222, and 1111 is never displayed.
6. load asserted exactly on the frame-boundary cycle, then rst_n pulsed low mid-next-frame -> 1st boundary transfers the prior shadow. Reset forces all outputs to reset values asynchronously, with no upd_done afterward.
